// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, fill values.
package alu_pkg;

  localparam logic [3:0] OP_SHL  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_MULU = 4'd3;
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;
  localparam logic [3:0] OP_MULS = 4'd13;
  localparam logic [3:0] OP_DIVS = 4'd14;

  typedef enum logic {ST_IDLE, ST_ITER} state_e;

  // Bit replicated across the quotient on divide by zero.
  localparam logic DIV_ZERO_FILL = 1'b1;

  // Ops served by the iterative multiply/divide datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_MULS) || (op == OP_DIVS);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative WIDTH-cycle multiply (shift/add) and restoring divide (shift/subtract).
// Operands are reduced to magnitudes on start; signs are reapplied on the last step.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, mq_q, mcand_q, x_q;
  logic             div_q, neg_lo_q, neg_hi_q, dz_q;

  logic [WIDTH:0]     sum, shifted, diff;
  logic [WIDTH-1:0]   acc_nx, mq_nx;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // One iteration step of whichever operation is in flight.
  always_comb begin
    sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
    shifted = {acc_q, mq_q[WIDTH-1]};
    diff    = shifted - {1'b0, mcand_q};
    if (div_q) begin
      // Borrow out of the top bit means the trial subtract failed: restore.
      if (diff[WIDTH]) begin
        acc_nx = shifted[WIDTH-1:0];
        mq_nx  = {mq_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_nx = diff[WIDTH-1:0];
        mq_nx  = {mq_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_nx = sum[WIDTH:1];
      mq_nx  = {sum[0], mq_q[WIDTH-1:1]};
    end
  end

  // Final sign fix and special cases, valid in the cycle done is high.
  always_comb begin
    prod = {acc_nx, mq_nx};
    if (neg_lo_q) prod = -prod;
    if (div_q) begin
      if (dz_q) begin
        res_lo = {WIDTH{DIV_ZERO_FILL}};
        res_hi = x_q;
      end else begin
        res_lo = neg_lo_q ? -mq_nx : mq_nx;
        res_hi = neg_hi_q ? -acc_nx : acc_nx;
      end
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
    done = busy_q && (cnt_q == LAST);
  end

  // Operand load on start, then one step per cycle for WIDTH cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      mcand_q  <= '0;
      x_q      <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= mag(a, is_signed);
      mcand_q  <= mag(b, is_signed);
      x_q      <= a;
      div_q    <= is_div;
      neg_lo_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_q <= is_signed && a[WIDTH-1];
      dz_q     <= is_div && (b == '0);
    end else if (busy_q) begin
      acc_q <= acc_nx;
      mq_q  <= mq_nx;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/shift/add/compare ops plus iterative
// multiply/divide. Outputs are registered and held until consumed.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result2,
  output logic             OF,
  output logic             CF,
  output logic             equal
);

  localparam int unsigned SW = $clog2(WIDTH);

  state_e state_q, state_d;
  logic   accept, start, single, eq_pend_q;

  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  logic [WIDTH:0]   add_full, sub_full;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_of, sc_cf;

  assign accept = in_valid && in_ready;
  assign start  = accept && is_iter_op(sel);
  assign single = accept && !is_iter_op(sel);

  iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_div   ((sel == OP_DIVU) || (sel == OP_DIVS)),
    .is_signed((sel == OP_MULS) || (sel == OP_DIVS)),
    .a        (x),
    .b        (y),
    .done     (md_done),
    .res_lo   (md_lo),
    .res_hi   (md_hi)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)   state_d = ST_ITER;
      ST_ITER: if (md_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only when idle and no result is stalled.
  always_comb begin
    in_ready = (state_q == ST_IDLE) && !(out_valid && !out_ready);
  end

  // Single-cycle op results.
  always_comb begin
    add_full = {1'b0, x} + {1'b0, y};
    sub_full = {1'b0, x} + {1'b0, ~y} + (WIDTH + 1)'(1);
    shamt    = y[SW-1:0];
    sc_res   = '0;
    sc_of    = 1'b0;
    sc_cf    = 1'b0;
    case (sel)
      OP_SHL:  sc_res = x << shamt;
      OP_SRA:  sc_res = $unsigned($signed(x) >>> shamt);
      OP_SRL:  sc_res = x >> shamt;
      OP_ADD: begin
        sc_res = add_full[WIDTH-1:0];
        sc_cf  = add_full[WIDTH];
        sc_of  = (x[WIDTH-1] == y[WIDTH-1]) && (add_full[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_full[WIDTH-1:0];
        sc_cf  = sub_full[WIDTH];
        sc_of  = (x[WIDTH-1] != y[WIDTH-1]) && (sub_full[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND:  sc_res = x & y;
      OP_OR:   sc_res = x | y;
      OP_XOR:  sc_res = x ^ y;
      OP_NOR:  sc_res = ~(x | y);
      OP_SLT:  sc_res = {{(WIDTH - 1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: sc_res = {{(WIDTH - 1){1'b0}}, (x < y)};
      default: sc_res = '0;
    endcase
  end

  // Output registers: load on single-cycle accept or iterative finish, clear valid on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      result2   <= '0;
      OF        <= 1'b0;
      CF        <= 1'b0;
      equal     <= 1'b0;
      eq_pend_q <= 1'b0;
    end else begin
      if (start) eq_pend_q <= (x == y);
      if (single) begin
        out_valid <= 1'b1;
        result    <= sc_res;
        result2   <= '0;
        OF        <= sc_of;
        CF        <= sc_cf;
        // The reserved code reports all-zero outputs, including equal.
        equal     <= (sel != 4'd15) && (x == y);
      end else if (md_done) begin
        out_valid <= 1'b1;
        result    <= md_lo;
        result2   <= md_hi;
        OF        <= 1'b0;
        CF        <= 1'b0;
        equal     <= eq_pend_q;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed bench for seq_alu (WIDTH=32) against an arithmetic model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0, y = '0;
  logic [3:0]  sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result, result2;
  logic        OF, CF, equal;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] r;
    logic [31:0] r2;
    logic        of;
    logic        cf;
    logic        eq;
  } exp_t;

  seq_alu #(
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .result2  (result2),
    .OF       (OF),
    .CF       (CF),
    .equal    (equal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_iter(input logic [3:0] op);
    return op == 4'd3 || op == 4'd4 || op == 4'd13 || op == 4'd14;
  endfunction

  // Reference model from plain 64-bit arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint           sa, sb, sr, q, rm;
    longint unsigned  ua, ub, ur;
    logic signed [31:0] sra;
    logic [63:0]      p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    e  = '{r: '0, r2: '0, of: 1'b0, cf: 1'b0, eq: (a == b)};
    case (op)
      4'd0: e.r = a << b[4:0];
      4'd1: begin sra = $signed(a) >>> b[4:0]; e.r = sra; end
      4'd2: e.r = a >> b[4:0];
      4'd3: begin p = ua * ub; e.r = p[31:0]; e.r2 = p[63:32]; end
      4'd4: begin
        if (b == 0) begin e.r = 32'hFFFF_FFFF; e.r2 = a; end
        else begin ur = ua / ub; e.r = ur[31:0]; ur = ua % ub; e.r2 = ur[31:0]; end
      end
      4'd5: begin
        ur = ua + ub; e.r = ur[31:0]; e.cf = ur[32];
        sr = sa + sb; e.of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd6: begin
        ur = ua - ub; e.r = ur[31:0]; e.cf = (a >= b);
        sr = sa - sb; e.of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd7:  e.r = a & b;
      4'd8:  e.r = a | b;
      4'd9:  e.r = a ^ b;
      4'd10: e.r = ~(a | b);
      4'd11: e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: e.r = (a < b) ? 32'd1 : 32'd0;
      4'd13: begin sr = sa * sb; p = sr; e.r = p[31:0]; e.r2 = p[63:32]; end
      4'd14: begin
        if (b == 0) begin e.r = 32'hFFFF_FFFF; e.r2 = a; end
        else begin q = sa / sb; rm = sa % sb; p = q; e.r = p[31:0]; p = rm; e.r2 = p[31:0]; end
      end
      default: e.eq = 1'b0;
    endcase
    return e;
  endfunction

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, ".result"}, {32'd0, result}, {32'd0, e.r});
    check({tag, ".result2"}, {32'd0, result2}, {32'd0, e.r2});
    check({tag, ".OF"}, {63'd0, OF}, {63'd0, e.of});
    check({tag, ".CF"}, {63'd0, CF}, {63'd0, e.cf});
    check({tag, ".equal"}, {63'd0, equal}, {63'd0, e.eq});
  endtask

  // Issue one op, wait for its result with a bound, check latency and values, consume.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int   n;
    exp_t e;
    e = model(op, a, b);
    @(negedge clk);
    in_valid = 1'b1; sel = op; x = a; y = b;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    x = $urandom; y = $urandom; sel = 4'($urandom);
    n = 1;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check({tag, ".latency"}, 64'(n), is_iter(op) ? 64'd33 : 64'd1);
    check_outs(tag, e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".consumed"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] corners [6];
    logic [31:0] a, b;
    logic [3:0]  op;
    corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset.out_valid", {63'd0, out_valid}, 64'd0);
    check("reset.in_ready", {63'd0, in_ready}, 64'd1);
    check_outs("reset", '{r: '0, r2: '0, of: 1'b0, cf: 1'b0, eq: 1'b0});

    // Directed corner cases.
    run_op("add_ovf", 4'd5, 32'h7FFF_FFFF, 32'd1);
    run_op("sub_borrow", 4'd6, 32'd0, 32'd1);
    run_op("sub_eq", 4'd6, 32'd5, 32'd5);
    run_op("mulu_max", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("muls_neg", 4'd13, -32'sd3, 32'd5);
    run_op("divu_zero", 4'd4, 32'd7, 32'd0);
    run_op("divs_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divs_neg", 4'd14, -32'sd7, 32'd2);
    run_op("divs_zero", 4'd14, -32'sd9, 32'd0);
    run_op("op15", 4'd15, 32'd3, 32'd3);

    // Backpressure: ADD result held while an XOR waits, then back-to-back.
    @(negedge clk);
    in_valid = 1'b1; sel = 4'd5; x = 32'd10; y = 32'd20;
    @(negedge clk);
    sel = 4'd9; x = 32'hF0F0_1234; y = 32'h0FF0_4321;
    e = model(4'd5, 32'd10, 32'd20);
    for (int i = 0; i < 5; i++) begin
      check("bp.hold_valid", {63'd0, out_valid}, 64'd1);
      check("bp.hold_ready", {63'd0, in_ready}, 64'd0);
      check("bp.hold_result", {32'd0, result}, {32'd0, e.r});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp.xor_valid", {63'd0, out_valid}, 64'd1);
    check_outs("bp.xor", model(4'd9, 32'hF0F0_1234, 32'h0FF0_4321));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during a DIVU iteration.
    in_valid = 1'b1; sel = 4'd4; x = 32'd1000; y = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_mid.no_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid.in_ready", {63'd0, in_ready}, 64'd1);
    check_outs("rst_mid", '{r: '0, r2: '0, of: 1'b0, cf: 1'b0, eq: 1'b0});
    run_op("slt_after_rst", 4'd11, 32'hFFFF_FFFF, 32'd1);

    // Randomized ops, operands biased toward corner values.
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked ALU for the single-cycle CPU's execute stage. It keeps the 13-operation encoding of the existing combinational ALU and adds signed multiply/divide and defined divide-by-zero and overflow results. Multiply and divide use a shared iterative shift/add datapath instead of combinational `*`, `/` and `%`. Logic, shift, add/sub and compare ops complete in one cycle; the core stalls via valid/ready.

## Interface

Parameters:
- `WIDTH`, 32: operand/result width; must be ≥ 4; shift amount is `y[$clog2(WIDTH)-1:0]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: block accepts a request this cycle.
- `x`, `y` in WIDTH: operands, sampled on accept.
- `sel` in 4: operation code.
- `out_valid` out 1: result registers valid.
- `out_ready` in 1: consumer takes the result.
- `result` out WIDTH: primary result (product low, quotient).
- `result2` out WIDTH: product high or remainder; 0 for all other ops.
- `OF`, `CF` out 1: add/sub flags; 0 for all other ops.
- `equal` out 1: registered `x == y` of the accepted operands, for every op.

## Operation

- Op codes: 0 SHL, 1 SRA, 2 SRL, 3 MULU, 4 DIVU, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 10 NOR, 11 SLT (signed), 12 SLTU, 13 MULS, 14 DIVS. Code 15 returns all-zero outputs with 1-cycle latency.
- Accept happens when `in_valid && in_ready`.
- `in_ready = (state==IDLE) && !(out_valid && !out_ready)`.
- State machine:
  - IDLE → ITER on accept of op 3, 4, 13 or 14.
  - IDLE → IDLE on accept of any other op; outputs are registered on the next edge.
  - ITER → IDLE after WIDTH iterations; outputs are loaded and `out_valid` is set.
- ADD: `x+y`. CF = carry out of the MSB. OF = carry into MSB XOR carry out.
- SUB: `x+~y+1`. CF = carry out, so 1 means no borrow. OF = carry into MSB XOR carry out.
- MULU: 2·WIDTH-bit unsigned product. `{result2,result}` = product.
- MULS: signed product, computed on magnitudes and negated when the operand signs differ.
- DIVU: restoring division, one quotient bit per cycle.
- DIVS:
  - Operates on magnitudes.
  - Quotient truncates toward zero; quotient is negated when the operand signs differ.
  - Remainder takes the sign of `x`.
- Divide by zero (ops 4 and 14): result = all ones, result2 = `x`.
- DIVS with `x` = most-negative value and `y` = −1: result = `x`, result2 = 0.
- Divide-by-zero and the DIVS overflow case still take the full WIDTH iterations.
- Output hold: `out_valid` stays high and all outputs are stable until `out_ready`. `out_valid` falls on the `out_valid && out_ready` edge unless a new result loads on that same edge.
- Simultaneous events: result consumed and new single-cycle op accepted in the same cycle → back-to-back `out_valid` with no bubble.

## Timing

- Reset values: `out_valid`=0, `result`=0, `result2`=0, `OF`=0, `CF`=0, `equal`=0, state=IDLE, so `in_ready`=1 in the first cycle after reset.
- Single-cycle ops: accepted at edge N → `out_valid` high after edge N+1.
- Iterative ops: accepted at edge N → `out_valid` high after edge N+1+WIDTH, i.e. 33 cycles for WIDTH=32. Latency is fixed and independent of the operands.
- Reset asserted mid-iteration or mid-hold: in-flight work is discarded and all outputs return to their reset values on that edge; `in_ready`=1 on the next cycle.
- `in_ready` is combinational from state and `out_ready`. There is no combinational path from `x`/`y`/`sel` to any output.

## Structure

- Package `alu_pkg`:
  - Op-code localparams (`OP_SHL` … `OP_DIVS`).
  - State encoding (`ST_IDLE`, `ST_ITER`).
  - Divide-by-zero fill constant.
- Sub-module `iter_muldiv`:
  - Shared WIDTH-cycle shift/add–shift/subtract datapath.
  - Iteration counter and sign-fix logic.
  - Its own start/done pulse.
- `seq_alu` contains the single-cycle ops, the FSM, the handshake and the output registers.

## Test plan

- ADD `x=0x7FFFFFFF`, `y=1` → result=0x80000000, OF=1, CF=0, `out_valid` 1 cycle after accept.
- SUB `x=0`, `y=1` → result=0xFFFFFFFF, CF=0, OF=0. SUB `x=5`, `y=5` → result=0, CF=1, equal=1.
- MULU `0xFFFFFFFF*0xFFFFFFFF` → result=1, result2=0xFFFFFFFE, `out_valid` exactly 33 cycles after accept. MULS `-3*5` → result=0xFFFFFFF1, result2=0xFFFFFFFF.
- DIVU `7/0` → result=0xFFFFFFFF, result2=7. DIVS `0x80000000/0xFFFFFFFF` → result=0x80000000, result2=0. DIVS `-7/2` → result=0xFFFFFFFD, result2=0xFFFFFFFF.
- Backpressure: hold `out_ready`=0 for 5 cycles after an ADD result → outputs stable and `in_ready`=0; then `out_ready`=1 with a queued XOR → XOR result valid on the very next cycle.
- Assert `rst` at iteration 10 of a DIVU → `out_valid`=0 and all outputs 0 next cycle, `in_ready`=1; a following SLT `-1<1` → result=1.
